bridge_rx_burst: RTL and testbench
==================================

// Module: bridge_rx_burst
// PURPOSE
//  Parametrised ASCII-to-bus request bridge. Sits between the UART receiver and the bus chain.
//  Parses hex read/write/burst-read commands from the byte stream and issues bus requests.
//  Adds configurable address/data widths, req_ready backpressure, burst reads and error reporting.
// PARAMETERS
//  ADDR_WIDTH  16  bus address width; multiple of 4; A_DIG = ADDR_WIDTH/4 hex digits
//  DATA_WIDTH  16  bus data width; multiple of 4; D_DIG = DATA_WIDTH/4 hex digits
//  CNT_WIDTH   8   burst count width; multiple of 4; C_DIG = CNT_WIDTH/4 hex digits
// PORTS
//  clk        in   1           system clock, all logic on rising edge
//  rst        in   1           synchronous active-high reset
//  axiid      in   8           received byte
//  axiiv      in   1           axiid valid, 1-cycle strobe, no backpressure
//  req_addr   out  ADDR_WIDTH  request address
//  req_data   out  DATA_WIDTH  write data; 0 for reads
//  req_rw     out  1           1 = write, 0 = read
//  req_valid  out  1           request valid; held until req_ready
//  req_ready  in   1           downstream accepts when req_valid && req_ready
//  err        out  1           1-cycle pulse on any protocol error
//  busy       out  1           high in ISSUE/BURST
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; digit counter, shift register and burst count cleared.
//  Commands: 'M'+A_DIG hex = read; 'M'+A_DIG+D_DIG hex = write; 'B'+A_DIG+C_DIG hex = burst read.
//  Terminator: CR (0x0D) or LF (0x0A). A terminator in IDLE is ignored silently, so CRLF is legal.
//  Hex digits 0-9, A-F, a-f. Command letters are uppercase only.
//  Digits shift into the shift register MSB-first; the digit counter saturates at A_DIG+D_DIG+1.
//  States:
//   IDLE:    'M' -> MSG; 'B' -> BRST; terminator -> IDLE; any other byte -> err, DISCARD.
//   MSG:     hex -> shift. Terminator: count A_DIG -> read ISSUE; count A_DIG+D_DIG -> write ISSUE.
//            Terminator with any other count -> err, IDLE. Non-hex byte -> err, DISCARD.
//   BRST:    hex -> shift. Terminator: count A_DIG+C_DIG with cnt != 0 -> BURST.
//            cnt == 0 or wrong count -> err, IDLE. Non-hex byte -> err, DISCARD.
//   DISCARD: drop bytes until a terminator, then IDLE.
//   ISSUE:   req_valid high with stable addr/data/rw.
//            On req_valid && req_ready: req_valid low next cycle; go IDLE, or DISCARD if overrun set.
//   BURST:   req_valid high, req_rw 0, req_data 0.
//            Each handshake: addr += 1 (mod 2^ADDR_WIDTH), cnt -= 1.
//            req_valid stays high back-to-back while cnt > 0; after the final beat, IDLE/DISCARD as ISSUE.
//  Latency: terminator byte in cycle N -> req_valid high in cycle N+1 (registered outputs).
//  Overrun: an axiiv byte in ISSUE/BURST is dropped, pulses err that cycle and sets the overrun flag.
//   Overrun does not abort the pending request or burst; the flag clears on entering DISCARD.
//  Simultaneous: handshake and axiiv in the same cycle -> byte is an overrun (the state is still ISSUE/BURST).
//  Reset mid-operation: rst wins. Next cycle req_valid=0, busy=0, err=0, state IDLE; partial burst abandoned.
//  Error pulse: err is high exactly the cycle after the offending byte; never high two cycles for one byte.
// TESTING
//  1. "M1234\r\n", req_ready=1: one req_valid cycle, addr 0x1234, rw=0, data 0; LF gives no err.
//  2. "M12345678\r": addr 0x1234, data 0x5678, rw=1; "Mabcd\r": read at 0xABCD.
//  3. "B001004\r", req_ready alternating 0/1: reads 0x0010..0x0013 in order.
//     Each beat is held until ready, then busy drops.
//  4. "BFFFE03\r": reads 0xFFFE, 0xFFFF, 0x0000 (wrap); "B001000\r": err, no request.
//  5. Errors, each -> single err pulse, no request, next valid command works:
//     "M12G4\r" (bad digit), "M123\r" (short), "X\r" (bad letter).
//  6. Overrun: "M0001\r" with req_ready=0, then send "M2\r" -> err per byte, read 0x0001 completes.
//     Next, rst mid-"B000010" burst -> req_valid 0 next cycle.

Source files
------------

// File: rtl/bridge_rx_burst.sv
// bridge_rx_burst: parses ASCII hex read/write/burst-read commands into bus requests.
// Latency: terminator byte in cycle N -> req_valid in cycle N+1; err pulses the cycle after its byte.
// Backpressure: request held until req_ready; bytes arriving while busy are dropped and flagged as overrun.
module bridge_rx_burst #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            axiid,
   input  logic                  axiiv,
   output logic [ADDR_WIDTH-1:0] req_addr,
   output logic [DATA_WIDTH-1:0] req_data,
   output logic                  req_rw,
   output logic                  req_valid,
   input  logic                  req_ready,
   output logic                  err,
   output logic                  busy
);

   localparam int A_DIG    = ADDR_WIDTH / 4;
   localparam int D_DIG    = DATA_WIDTH / 4;
   localparam int C_DIG    = CNT_WIDTH / 4;
   // The shift register must hold the longer of the write and burst commands.
   localparam int TAIL_W   = (DATA_WIDTH > CNT_WIDTH) ? DATA_WIDTH : CNT_WIDTH;
   localparam int SR_W     = ADDR_WIDTH + TAIL_W;
   localparam int TAIL_DIG = TAIL_W / 4;
   // One past the longest legal digit string, so overlong input can never alias a legal count.
   localparam int DCNT_MAX = A_DIG + TAIL_DIG + 1;
   localparam int DCNT_W   = $clog2(DCNT_MAX + 1);

   localparam logic [DCNT_W-1:0] DC_RD  = DCNT_W'(A_DIG);
   localparam logic [DCNT_W-1:0] DC_WR  = DCNT_W'(A_DIG + D_DIG);
   localparam logic [DCNT_W-1:0] DC_BR  = DCNT_W'(A_DIG + C_DIG);
   localparam logic [DCNT_W-1:0] DC_SAT = DCNT_W'(DCNT_MAX);

   localparam logic [7:0] CH_CR = 8'h0D;
   localparam logic [7:0] CH_LF = 8'h0A;
   localparam logic [7:0] CH_M  = 8'h4D;
   localparam logic [7:0] CH_B  = 8'h42;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MSG,
      S_BRST,
      S_DISCARD,
      S_ISSUE,
      S_BURST
   } state_t;

   // Returns {is_hex, nibble} for one ASCII byte; letters A-F in either case.
   function automatic logic [4:0] hex_nib(input logic [7:0] b);
      logic [4:0] r;
      r = 5'd0;
      if (b >= 8'h30 && b <= 8'h39) begin
         r = {1'b1, b[3:0]};
      end else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66)) begin
         r = {1'b1, b[3:0] + 4'd9};
      end
      return r;
   endfunction

   state_t                  state_q, state_d;
   logic [DCNT_W-1:0]       dcnt_q, dcnt_d;
   logic [SR_W-1:0]         sr_q, sr_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic                    rw_q, rw_d;
   logic                    valid_q, valid_d;
   logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
   logic                    ovr_q, ovr_d;
   logic                    err_q, err_d;
   logic                    busy_q, busy_d;

   logic [4:0]              hx;
   logic                    is_term;
   logic                    hs;
   logic                    last_beat;

   // Field views of the collected digits; the last digit received is the least significant.
   logic [ADDR_WIDTH-1:0]   rd_addr;
   logic [ADDR_WIDTH-1:0]   wr_addr;
   logic [DATA_WIDTH-1:0]   wr_data;
   logic [ADDR_WIDTH-1:0]   br_addr;
   logic [CNT_WIDTH-1:0]    br_cnt;

   assign hx      = hex_nib(axiid);
   assign is_term = (axiid == CH_CR) || (axiid == CH_LF);
   assign hs      = valid_q && req_ready;

   assign rd_addr = sr_q[ADDR_WIDTH-1:0];
   assign wr_addr = sr_q[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
   assign wr_data = sr_q[DATA_WIDTH-1:0];
   assign br_addr = sr_q[ADDR_WIDTH+CNT_WIDTH-1:CNT_WIDTH];
   assign br_cnt  = sr_q[CNT_WIDTH-1:0];

   // Next-state and registered-output computation for the command parser and request issuer.
   always_comb begin
      state_d   = state_q;
      dcnt_d    = dcnt_q;
      sr_d      = sr_q;
      addr_d    = addr_q;
      data_d    = data_q;
      rw_d      = rw_q;
      valid_d   = valid_q;
      cnt_d     = cnt_q;
      ovr_d     = ovr_q;
      err_d     = 1'b0;
      last_beat = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (axiiv) begin
               if (axiid == CH_M) begin
                  state_d = S_MSG;
                  dcnt_d  = '0;
                  sr_d    = '0;
               end else if (axiid == CH_B) begin
                  state_d = S_BRST;
                  dcnt_d  = '0;
                  sr_d    = '0;
               end else if (!is_term) begin
                  // Stray terminators are tolerated so CRLF line endings work.
                  err_d   = 1'b1;
                  state_d = S_DISCARD;
               end
            end
         end

         S_MSG: begin
            if (axiiv) begin
               if (hx[4]) begin
                  sr_d = {sr_q[SR_W-5:0], hx[3:0]};
                  if (dcnt_q != DC_SAT) dcnt_d = dcnt_q + DCNT_W'(1);
               end else if (is_term) begin
                  if (dcnt_q == DC_RD) begin
                     addr_d  = rd_addr;
                     data_d  = '0;
                     rw_d    = 1'b0;
                     valid_d = 1'b1;
                     state_d = S_ISSUE;
                  end else if (dcnt_q == DC_WR) begin
                     addr_d  = wr_addr;
                     data_d  = wr_data;
                     rw_d    = 1'b1;
                     valid_d = 1'b1;
                     state_d = S_ISSUE;
                  end else begin
                     err_d   = 1'b1;
                     state_d = S_IDLE;
                  end
               end else begin
                  err_d   = 1'b1;
                  state_d = S_DISCARD;
               end
            end
         end

         S_BRST: begin
            if (axiiv) begin
               if (hx[4]) begin
                  sr_d = {sr_q[SR_W-5:0], hx[3:0]};
                  if (dcnt_q != DC_SAT) dcnt_d = dcnt_q + DCNT_W'(1);
               end else if (is_term) begin
                  if (dcnt_q == DC_BR && br_cnt != '0) begin
                     addr_d  = br_addr;
                     cnt_d   = br_cnt;
                     data_d  = '0;
                     rw_d    = 1'b0;
                     valid_d = 1'b1;
                     state_d = S_BURST;
                  end else begin
                     err_d   = 1'b1;
                     state_d = S_IDLE;
                  end
               end else begin
                  err_d   = 1'b1;
                  state_d = S_DISCARD;
               end
            end
         end

         S_DISCARD: begin
            if (axiiv && is_term) state_d = S_IDLE;
         end

         S_ISSUE, S_BURST: begin
            // Bytes cannot be buffered while a request is outstanding; drop and remember.
            if (axiiv) begin
               err_d = 1'b1;
               ovr_d = 1'b1;
            end
            if (hs) begin
               if (state_q == S_BURST) begin
                  addr_d    = addr_q + ADDR_WIDTH'(1);
                  cnt_d     = cnt_q - CNT_WIDTH'(1);
                  last_beat = (cnt_q == CNT_WIDTH'(1));
               end else begin
                  last_beat = 1'b1;
               end
               if (last_beat) begin
                  valid_d = 1'b0;
                  // After an overrun the rest of that line is garbage; resync at the next terminator.
                  if (ovr_d) begin
                     state_d = S_DISCARD;
                     ovr_d   = 1'b0;
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end
         end

         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
         end
      endcase

      busy_d = (state_d == S_ISSUE) || (state_d == S_BURST);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         dcnt_q  <= '0;
         sr_q    <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         rw_q    <= 1'b0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
         ovr_q   <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dcnt_q  <= dcnt_d;
         sr_q    <= sr_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         rw_q    <= rw_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
         ovr_q   <= ovr_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end

   assign req_addr  = addr_q;
   assign req_data  = data_q;
   assign req_rw    = rw_q;
   assign req_valid = valid_q;
   assign err       = err_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_bridge_rx_burst.sv
// tb_bridge_rx_burst: directed and randomized checks of the ASCII command bridge.
// Latency: n/a (testbench).
// Backpressure: drives req_ready in fixed, alternating, random or stalled patterns.
module tb_bridge_rx_burst;

   typedef struct packed {
      logic [15:0] addr;
      logic [15:0] data;
      logic        rw;
   } req_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  axiid = 8'h00;
   logic        axiiv = 1'b0;
   logic [15:0] req_addr;
   logic [15:0] req_data;
   logic        req_rw;
   logic        req_valid;
   logic        req_ready = 1'b0;
   logic        err;
   logic        busy;

   int errors = 0;
   int checks = 0;
   int rdy_mode = 0;   // 0: always ready, 1: random, 2: alternating, 3: stalled
   int err_cnt = 0;
   int valid_cyc = 0;
   req_t got_q[$];
   req_t exp_q[$];
   int exp_err = 0;

   bridge_rx_burst #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .CNT_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .axiid(axiid), .axiiv(axiiv),
      .req_addr(req_addr), .req_data(req_data), .req_rw(req_rw),
      .req_valid(req_valid), .req_ready(req_ready), .err(err), .busy(busy)
   );

   always #5 clk = ~clk;

   // Ready pattern generator, changes just after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0: req_ready = 1'b1;
            1: req_ready = 1'($urandom % 2);
            2: req_ready = !req_ready;
            default: req_ready = 1'b0;
         endcase
      end
   end

   // Downstream observer: records accepted requests, err cycles and valid cycles.
   always @(negedge clk) begin
      if (!rst) begin
         if (req_valid && req_ready) got_q.push_back(req_t'({req_addr, req_data, req_rw}));
         if (err) err_cnt++;
         if (req_valid) valid_cyc++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic bit is_hex(input logic [7:0] c);
      return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66);
   endfunction

   function automatic int hexval(input logic [7:0] c);
      if (c <= 8'h39) return int'(c) - 48;
      if (c >= 8'h61) return int'(c) - 97 + 10;
      return int'(c) - 65 + 10;
   endfunction

   // Interprets one command line (without terminator) and appends expected results.
   function automatic void model_line(input string l);
      logic [7:0]      c0;
      int              nd;
      bit              allhex;
      longint unsigned v;
      req_t            r;
      c0 = l.getc(0);
      nd = l.len() - 1;
      allhex = 1'b1;
      v = 0;
      for (int i = 1; i < l.len(); i++) begin
         if (is_hex(l.getc(i))) v = (v << 4) | longint'(hexval(l.getc(i)));
         else allhex = 1'b0;
      end
      if (c0 == 8'h4D) begin
         if (!allhex || !(nd == 4 || nd == 8)) exp_err++;
         else if (nd == 4) begin
            r.addr = v[15:0]; r.data = 16'h0; r.rw = 1'b0; exp_q.push_back(r);
         end else begin
            r.addr = v[31:16]; r.data = v[15:0]; r.rw = 1'b1; exp_q.push_back(r);
         end
      end else if (c0 == 8'h42) begin
         if (!allhex || nd != 6 || v[7:0] == 8'h00) exp_err++;
         else begin
            for (int k = 0; k < int'(v[7:0]); k++) begin
               r.addr = 16'(v[23:8] + 64'(k)); r.data = 16'h0; r.rw = 1'b0; exp_q.push_back(r);
            end
         end
      end else begin
         exp_err++;
      end
   endfunction

   // Splits a byte stream at CR/LF; empty lines are ignored.
   function automatic void model_stream(input string s);
      int st;
      st = 0;
      for (int i = 0; i < s.len(); i++) begin
         if (s.getc(i) == 8'h0D || s.getc(i) == 8'h0A) begin
            if (i > st) model_line(s.substr(st, i - 1));
            st = i + 1;
         end
      end
   endfunction

   // ---------------- drivers ----------------
   task automatic send_byte(input logic [7:0] b);
      axiid = b;
      axiiv = 1'b1;
      @(posedge clk);
      #1;
      axiiv = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL wait_idle: busy=%0b after %0d cycles, required 0", busy, n);
      end
   endtask

   task automatic settle();
      repeat (3) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_str(input string s, input bit wait_term);
      logic [7:0] c;
      for (int i = 0; i < s.len(); i++) begin
         c = s.getc(i);
         send_byte(c);
         if (wait_term && (c == 8'h0D || c == 8'h0A)) wait_idle();
         else repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic clear_obs();
      got_q.delete();
      exp_q.delete();
      exp_err = 0;
      err_cnt = 0;
      valid_cyc = 0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      checks++;
      if ({req_valid, busy, err, req_rw} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ctrl: valid/busy/err/rw=%b, required 0000", {req_valid, busy, err, req_rw});
      end
      checks++;
      if (req_addr !== 16'h0 || req_data !== 16'h0) begin
         errors++;
         $display("FAIL reset_bus: addr=%h data=%h, required 0000 0000", req_addr, req_data);
      end
      rst = 1'b0;
      settle();
   endtask

   task automatic test_read_single();
      rdy_mode = 0;
      settle();
      clear_obs();
      send_str("M1234", 1'b0);
      send_byte(8'h0D);
      checks++;
      if (req_valid !== 1'b1) begin
         errors++;
         $display("FAIL read_latency: req_valid=%b one cycle after CR, required 1", req_valid);
      end
      wait_idle();
      send_byte(8'h0A);
      settle();
      checks++;
      if (got_q.size() !== 1 || got_q[0] !== req_t'({16'h1234, 16'h0, 1'b0})) begin
         errors++;
         $display("FAIL read_single: n=%0d first=%h, required n=1 %h", got_q.size(),
                  got_q.size() > 0 ? got_q[0] : '0, req_t'({16'h1234, 16'h0, 1'b0}));
      end
      checks++;
      if (valid_cyc !== 1 || err_cnt !== 0) begin
         errors++;
         $display("FAIL read_single_pulse: valid_cycles=%0d err_cycles=%0d, required 1 0", valid_cyc, err_cnt);
      end
   endtask

   task automatic test_write_read();
      rdy_mode = 0;
      clear_obs();
      send_str("M12345678\rMabcd\r", 1'b1);
      settle();
      checks++;
      if (got_q.size() !== 2) begin
         errors++;
         $display("FAIL write_read_count: n=%0d, required 2", got_q.size());
      end else begin
         checks++;
         if (got_q[0] !== req_t'({16'h1234, 16'h5678, 1'b1})) begin
            errors++;
            $display("FAIL write: got %h, required %h", got_q[0], req_t'({16'h1234, 16'h5678, 1'b1}));
         end
         checks++;
         if (got_q[1] !== req_t'({16'hABCD, 16'h0, 1'b0})) begin
            errors++;
            $display("FAIL read_lower: got %h, required %h", got_q[1], req_t'({16'hABCD, 16'h0, 1'b0}));
         end
      end
   endtask

   task automatic test_burst_alt();
      bit          stall;
      logic [15:0] pa;
      rdy_mode = 2;
      clear_obs();
      send_str("B001004", 1'b0);
      send_byte(8'h0D);
      stall = 1'b0;
      pa = 16'h0;
      for (int n = 0; n < 60 && busy; n++) begin
         @(negedge clk);
         if (stall) begin
            checks++;
            if (req_valid !== 1'b1 || req_addr !== pa) begin
               errors++;
               $display("FAIL burst_hold: valid=%b addr=%h, required 1 %h", req_valid, req_addr, pa);
            end
         end
         stall = req_valid && !req_ready;
         pa = req_addr;
         @(posedge clk);
         #1;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL burst_busy: busy=%b after burst, required 0", busy);
      end
      checks++;
      if (got_q.size() !== 4) begin
         errors++;
         $display("FAIL burst_count: n=%0d, required 4", got_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_q[i] !== req_t'({16'(16'h0010 + i), 16'h0, 1'b0})) begin
               errors++;
               $display("FAIL burst_beat%0d: got %h, required addr %h read", i, got_q[i], 16'(16'h0010 + i));
            end
         end
      end
      rdy_mode = 0;
      settle();
   endtask

   task automatic test_burst_wrap();
      rdy_mode = 0;
      clear_obs();
      send_str("BFFFE03\rB001000\r", 1'b1);
      settle();
      checks++;
      if (got_q.size() !== 3 || got_q[0].addr !== 16'hFFFE || got_q[1].addr !== 16'hFFFF
          || got_q[2].addr !== 16'h0000) begin
         errors++;
         $display("FAIL burst_wrap: n=%0d addrs=%h %h %h, required 3 fffe ffff 0000", got_q.size(),
                  got_q.size() > 0 ? got_q[0].addr : 16'hx, got_q.size() > 1 ? got_q[1].addr : 16'hx,
                  got_q.size() > 2 ? got_q[2].addr : 16'hx);
      end
      checks++;
      if (err_cnt !== 1) begin
         errors++;
         $display("FAIL burst_zero_err: err_cycles=%0d, required 1", err_cnt);
      end
   endtask

   task automatic test_errors();
      string bad [3];
      bad[0] = "M12G4\r";
      bad[1] = "M123\r";
      bad[2] = "X\r";
      rdy_mode = 0;
      for (int i = 0; i < 3; i++) begin
         clear_obs();
         send_str(bad[i], 1'b1);
         settle();
         send_str("M4321\r", 1'b1);
         settle();
         checks++;
         if (err_cnt !== 1 || got_q.size() !== 1 || got_q[0] !== req_t'({16'h4321, 16'h0, 1'b0})) begin
            errors++;
            $display("FAIL error_case%0d: err_cycles=%0d n=%0d, required 1 err then one read of 4321",
                     i, err_cnt, got_q.size());
         end
      end
      // err must appear exactly the cycle after the offending byte and last one cycle.
      send_byte(8'h51);
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL err_timing: err=%b after bad byte, required 1", err);
      end
      @(posedge clk);
      #1;
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL err_width: err=%b second cycle, required 0", err);
      end
      send_byte(8'h0D);
      settle();
   endtask

   task automatic test_overrun();
      rdy_mode = 3;
      settle();
      clear_obs();
      send_str("M0001", 1'b0);
      send_byte(8'h0D);
      send_str("M2\r", 1'b0);
      settle();
      checks++;
      if (err_cnt !== 3 || got_q.size() !== 0 || req_valid !== 1'b1 || req_addr !== 16'h0001) begin
         errors++;
         $display("FAIL overrun_hold: err_cycles=%0d n=%0d valid=%b addr=%h, required 3 0 1 0001",
                  err_cnt, got_q.size(), req_valid, req_addr);
      end
      rdy_mode = 0;
      wait_idle();
      settle();
      checks++;
      if (got_q.size() !== 1 || got_q[0] !== req_t'({16'h0001, 16'h0, 1'b0})) begin
         errors++;
         $display("FAIL overrun_complete: n=%0d, required one read of 0001", got_q.size());
      end
      // The overrun leaves the bridge discarding until the next terminator.
      clear_obs();
      send_str("M5555\rM0002\r", 1'b1);
      settle();
      checks++;
      if (err_cnt !== 0 || got_q.size() !== 1 || got_q[0] !== req_t'({16'h0002, 16'h0, 1'b0})) begin
         errors++;
         $display("FAIL overrun_discard: err_cycles=%0d n=%0d, required 0 errs and one read of 0002",
                  err_cnt, got_q.size());
      end
   endtask

   task automatic test_reset_mid_burst();
      rdy_mode = 0;
      settle();
      clear_obs();
      send_str("B000010", 1'b0);
      send_byte(8'h0D);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({req_valid, busy, err} !== 3'b000) begin
         errors++;
         $display("FAIL rst_mid_burst: valid/busy/err=%b, required 000", {req_valid, busy, err});
      end
      rst = 1'b0;
      checks++;
      if (got_q.size() !== 3 || got_q[0].addr !== 16'h0 || got_q[1].addr !== 16'h1 || got_q[2].addr !== 16'h2) begin
         errors++;
         $display("FAIL rst_prefix: n=%0d, required beats 0000 0001 0002", got_q.size());
      end
      clear_obs();
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      checks++;
      if (valid_cyc !== 0 || got_q.size() !== 0) begin
         errors++;
         $display("FAIL rst_abandon: valid_cycles=%0d n=%0d, required 0 0", valid_cyc, got_q.size());
      end
      send_str("M00AA\r", 1'b1);
      settle();
      checks++;
      if (got_q.size() !== 1 || got_q[0] !== req_t'({16'h00AA, 16'h0, 1'b0})) begin
         errors++;
         $display("FAIL rst_recover: n=%0d, required one read of 00aa", got_q.size());
      end
   endtask

   task automatic test_random();
      string       s;
      string       term;
      logic [15:0] a;
      logic [15:0] d;
      int          kind;
      int          cnt;
      bit          lc;
      rdy_mode = 1;
      for (int t = 0; t < 40; t++) begin
         clear_obs();
         kind = $urandom_range(0, 7);
         lc   = 1'($urandom % 2);
         a    = 16'($urandom);
         d    = 16'($urandom);
         cnt  = $urandom_range(1, 4);
         if ($urandom_range(0, 2) == 0) a = 16'hFFFD + 16'($urandom_range(0, 2));
         case (kind)
            0: s = lc ? $sformatf("M%04x", a) : $sformatf("M%04X", a);
            1: s = lc ? $sformatf("M%04x%04x", a, d) : $sformatf("M%04X%04X", a, d);
            2: s = lc ? $sformatf("B%04x%02x", a, cnt[7:0]) : $sformatf("B%04X%02X", a, cnt[7:0]);
            3: s = $sformatf("Q%02X", a[7:0]);
            4: s = $sformatf("M%02XZ%01X", a[7:0], a[3:0]);
            5: s = $sformatf("M%03X", a[11:0]);
            6: s = $sformatf("B%04X00", a);
            default: s = $sformatf("M%04X%04X%01X", a, d, a[3:0]);
         endcase
         case ($urandom_range(0, 2))
            0: term = "\r";
            1: term = "\n";
            default: term = "\r\n";
         endcase
         s = {s, term};
         model_stream(s);
         send_str(s, 1'b1);
         settle();
         checks++;
         if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL rand%0d_count: cmd=%s n=%0d, required %0d", t, s.substr(0, s.len() - 2),
                     got_q.size(), exp_q.size());
         end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
               checks++;
               if (got_q[i] !== exp_q[i]) begin
                  errors++;
                  $display("FAIL rand%0d_req%0d: got %h, required %h", t, i, got_q[i], exp_q[i]);
               end
            end
         end
         checks++;
         if (err_cnt !== exp_err) begin
            errors++;
            $display("FAIL rand%0d_err: err_cycles=%0d, required %0d", t, err_cnt, exp_err);
         end
      end
      rdy_mode = 0;
      settle();
   endtask

   initial begin
      test_reset();
      test_read_single();
      test_write_read();
      test_burst_alt();
      test_burst_wrap();
      test_errors();
      test_overrun();
      test_reset_mid_burst();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
